// File: rtl/ahb_gpio_debounce_pkg.sv
// rtl/ahb_gpio_debounce_pkg.sv - register map and reset constants for the pin debouncer
package ahb_gpio_debounce_pkg;

  // Word offsets as seen on HADDR[4:2]
  localparam logic [2:0] CLEAN_OFF    = 3'd0;
  localparam logic [2:0] DB_LIMIT_OFF = 3'd1;
  localparam logic [2:0] STATUS_OFF   = 3'd2;
  localparam logic [2:0] RISE_EN_OFF  = 3'd3;
  localparam logic [2:0] FALL_EN_OFF  = 3'd4;

  localparam int DB_LIMIT_RST = 32'h0000_03E8;

endpackage

// File: rtl/gpio_db_bit.sv
// rtl/gpio_db_bit.sv - one pin: two-flop synchronizer, debounce counter and clean flop
module gpio_db_bit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pin,
  input  logic [CNT_W-1:0] limit,
  output logic             clean,
  output logic             rise,
  output logic             fall
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             update;

  // Pulses are combinational so STATUS latches on the same edge as clean
  assign update = (sync2 != clean) && (cnt >= limit);
  assign rise   = update & sync2;
  assign fall   = update & ~sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      clean <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (sync2 == clean) begin
        cnt <= '0;
      end else if (update) begin
        clean <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ahb_gpio_debounce.sv
// rtl/ahb_gpio_debounce.sv - AHB-Lite slave conditioning raw pins with edge interrupts
module ahb_gpio_debounce
  import ahb_gpio_debounce_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic             HREADY,
  output logic             HREADYOUT,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  input  logic [WIDTH-1:0] PIN_IN,
  output logic [WIDTH-1:0] PIN_CLEAN,
  output logic             IRQ
);

  logic             valid_q;
  logic             write_q;
  logic [2:0]       addr_q;
  logic             wr_en;
  logic [CNT_W-1:0] db_limit;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] status_set;
  logic [WIDTH-1:0] status_clr;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_db_bit #(.CNT_W(CNT_W)) u_bit (
      .clk   (HCLK),
      .rst_n (HRESETn),
      .pin   (PIN_IN[i]),
      .limit (db_limit),
      .clean (PIN_CLEAN[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
    end else if (HREADY) begin
      valid_q <= HSEL & HTRANS[1];
      if (HSEL && HTRANS[1]) begin
        write_q <= HWRITE;
        addr_q  <= HADDR[4:2];
      end
    end
  end

  assign wr_en      = valid_q & write_q;
  assign status_set = (rise & rise_en) | (fall & fall_en);
  assign status_clr = (wr_en && addr_q == STATUS_OFF) ? HWDATA[WIDTH-1:0] : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      db_limit <= CNT_W'(DB_LIMIT_RST);
      status   <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else begin
      if (wr_en && addr_q == DB_LIMIT_OFF) db_limit <= HWDATA[CNT_W-1:0];
      if (wr_en && addr_q == RISE_EN_OFF)  rise_en  <= HWDATA[WIDTH-1:0];
      if (wr_en && addr_q == FALL_EN_OFF)  fall_en  <= HWDATA[WIDTH-1:0];
      // A new edge outranks a simultaneous write-1-to-clear
      status <= (status & ~status_clr) | status_set;
    end
  end

  always_comb begin
    rdata = '0;
    if (valid_q && !write_q) begin
      case (addr_q)
        CLEAN_OFF:    rdata = 32'(PIN_CLEAN);
        DB_LIMIT_OFF: rdata = 32'(db_limit);
        STATUS_OFF:   rdata = 32'(status);
        RISE_EN_OFF:  rdata = 32'(rise_en);
        FALL_EN_OFF:  rdata = 32'(fall_en);
        default:      rdata = '0;
      endcase
    end
  end

  assign HRDATA    = rdata;
  assign HREADYOUT = 1'b1;
  assign IRQ       = |status;

endmodule

// File: tb/tb_ahb_gpio_debounce.sv
// tb/tb_ahb_gpio_debounce.sv - directed self-checking bench for ahb_gpio_debounce
module tb_ahb_gpio_debounce;

  localparam logic [31:0] A_CLEAN  = 32'h00;
  localparam logic [31:0] A_LIMIT  = 32'h04;
  localparam logic [31:0] A_STATUS = 32'h08;
  localparam logic [31:0] A_RISE   = 32'h0C;
  localparam logic [31:0] A_FALL   = 32'h10;
  localparam logic [31:0] A_NONE   = 32'h14;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic        HWRITE = 1'b0;
  logic        HREADY = 1'b1;
  logic        HREADYOUT;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic [15:0] PIN_IN = '0;
  logic [15:0] PIN_CLEAN;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tab[10];

  ahb_gpio_debounce #(.WIDTH(16), .CNT_W(16)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .PIN_IN    (PIN_IN),
    .PIN_CLEAN (PIN_CLEAN),
    .IRQ       (IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic apply_vec(input vec_t v);
    logic [31:0] rd;
    if (v.wr) begin
      ahb_write(v.addr, v.wdata);
    end else begin
      ahb_read(v.addr, rd);
      check(v.name, rd, v.exp);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        seen;

    tab[0] = '{A_CLEAN,  1'b0, 32'h0, 32'h0000_0000, "rst_clean"};
    tab[1] = '{A_LIMIT,  1'b0, 32'h0, 32'h0000_03E8, "rst_limit"};
    tab[2] = '{A_STATUS, 1'b0, 32'h0, 32'h0000_0000, "rst_status"};
    tab[3] = '{A_RISE,   1'b0, 32'h0, 32'h0000_0000, "rst_rise_en"};
    tab[4] = '{A_FALL,   1'b0, 32'h0, 32'h0000_0000, "rst_fall_en"};
    tab[5] = '{A_NONE,   1'b0, 32'h0, 32'h0000_0000, "rst_unmapped"};
    tab[6] = '{A_STATUS, 1'b1, 32'h1, 32'h0000_0000, "w1c_bit0"};
    tab[7] = '{A_STATUS, 1'b0, 32'h0, 32'h0000_0002, "w1c_after_bit0"};
    tab[8] = '{A_STATUS, 1'b1, 32'h2, 32'h0000_0000, "w1c_bit1"};
    tab[9] = '{A_STATUS, 1'b0, 32'h0, 32'h0000_0000, "w1c_after_bit1"};

    // Reset state
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_pin_clean", 32'(PIN_CLEAN), 32'h0);
    check("rst_irq", 32'(IRQ), 32'h0);
    check("rst_hreadyout", 32'(HREADYOUT), 32'h1);
    check("rst_hrdata", HRDATA, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 6; i++) apply_vec(tab[i]);
    check("rst_irq_after", 32'(IRQ), 32'h0);

    // Debounce latency with limit 4: clean rises at edge 7
    ahb_write(A_LIMIT, 32'd4);
    @(negedge HCLK);
    PIN_IN[0] = 1'b1;
    repeat (6) @(posedge HCLK);
    #1;
    check("lat_edge6", 32'(PIN_CLEAN[0]), 32'h0);
    @(posedge HCLK);
    #1;
    check("lat_edge7", 32'(PIN_CLEAN[0]), 32'h1);

    // 4-cycle glitch on pin1 is filtered
    @(negedge HCLK);
    PIN_IN[1] = 1'b1;
    repeat (4) @(negedge HCLK);
    PIN_IN[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge HCLK);
      #1;
      seen = seen | PIN_CLEAN[1];
    end
    check("glitch_filtered", 32'(seen), 32'h0);

    // Edge interrupts, enables not retroactive, W1C
    ahb_write(A_LIMIT, 32'd0);
    @(negedge HCLK);
    PIN_IN = '0;
    repeat (6) @(posedge HCLK);
    ahb_write(A_RISE, 32'h0001);
    ahb_write(A_FALL, 32'h0002);
    ahb_read(A_STATUS, rd);
    check("not_retroactive", rd, 32'h0);
    @(negedge HCLK);
    PIN_IN[0] = 1'b1;
    PIN_IN[1] = 1'b1;
    repeat (6) @(posedge HCLK);
    @(negedge HCLK);
    PIN_IN[1] = 1'b0;
    repeat (6) @(posedge HCLK);
    #1;
    check("edge_irq", 32'(IRQ), 32'h1);
    ahb_read(A_STATUS, rd);
    check("edge_status", rd, 32'h3);
    for (int i = 6; i < 10; i++) apply_vec(tab[i]);
    check("w1c_irq_low", 32'(IRQ), 32'h0);

    // Set beats clear: W1C data phase ends on the edge pin0 rises
    @(negedge HCLK);
    PIN_IN[0] = 1'b0;
    repeat (6) @(posedge HCLK);
    @(negedge HCLK);
    PIN_IN[0] = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = A_STATUS;
    @(posedge HCLK);
    #1;
    check("sbc_pre_edge", 32'(PIN_CLEAN[0]), 32'h0);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h1;
    @(posedge HCLK);
    #1;
    check("sbc_clean_edge", 32'(PIN_CLEAN[0]), 32'h1);
    check("sbc_irq", 32'(IRQ), 32'h1);
    ahb_read(A_STATUS, rd);
    check("sbc_status", rd, 32'h1);
    ahb_write(A_STATUS, 32'h1);
    ahb_read(A_STATUS, rd);
    check("sbc_cleared", rd, 32'h0);

    // Lowering the limit below an in-flight count
    ahb_write(A_LIMIT, 32'd100);
    @(negedge HCLK);
    PIN_IN[2] = 1'b1;
    repeat (50) @(posedge HCLK);
    ahb_write(A_LIMIT, 32'd10);
    check("lim_write_edge", 32'(PIN_CLEAN[2]), 32'h0);
    @(posedge HCLK);
    #1;
    check("lim_next_edge", 32'(PIN_CLEAN[2]), 32'h1);

    // Reset asserted mid-count
    ahb_write(A_RISE, 32'hFFFF);
    @(negedge HCLK);
    PIN_IN[3] = 1'b1;
    repeat (16) @(posedge HCLK);
    #1;
    check("pre_rst_irq", 32'(IRQ), 32'h1);
    @(negedge HCLK);
    PIN_IN[4] = 1'b1;
    repeat (4) @(posedge HCLK);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = A_CLEAN;
    @(posedge HCLK);
    #1;
    check("pre_rst_rdata", HRDATA, 32'h000D);
    #2;
    HRESETn = 1'b0;
    #1;
    check("async_pin_clean", 32'(PIN_CLEAN), 32'h0);
    check("async_irq", 32'(IRQ), 32'h0);
    check("async_hrdata", HRDATA, 32'h0);
    check("async_hreadyout", 32'(HREADYOUT), 32'h1);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    ahb_read(A_LIMIT, rd);
    check("post_rst_limit", rd, 32'h3E8);
    ahb_read(A_RISE, rd);
    check("post_rst_rise_en", rd, 32'h0);
    repeat (900) @(posedge HCLK);
    #1;
    check("requal_pending", 32'(PIN_CLEAN), 32'h0);
    repeat (110) @(posedge HCLK);
    #1;
    check("requal_done", 32'(PIN_CLEAN), 32'h001D);
    ahb_read(A_STATUS, rd);
    check("post_rst_status", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
